// File: rtl/stmm_pkg.sv
// Shared types and helpers for the stmm weight-fetch path.
package stmm_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/stmm_skid_fifo.sv
// Small registered FIFO; push and pop may coincide in any fill state, output is the registered head.
module stmm_skid_fifo #(
    parameter  int DW    = 129,
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic [CW-1:0] o_cnt,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_cnt != '0);
    // When full, a same-cycle pop frees the head slot, which is exactly where the write lands.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_cnt   = r_cnt;
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/bram_fetch.sv
// Walks a contiguous (wrapping) row range of the weight BRAM and streams rows out with
// valid/ready/last, hiding the 1-cycle read latency behind a credit-gated 2-entry FIFO.
module bram_fetch
    import stmm_pkg::*;
#(
    parameter  int L  = 176,
    parameter  int W  = 128,
    localparam int AW = addr_w(L)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [AW:0]   i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_mem_addr,
    input  logic [W-1:0]  i_mem_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [W-1:0]  o_out_data,
    output logic          o_out_last
);

    localparam logic [AW-1:0] ADDR_MAX = AW'(L - 1);
    localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_next;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_mem_addr;
    logic [AW-1:0] w_addr_inc;
    logic [AW:0]   r_len;
    logic [AW:0]   r_issue_cnt;
    logic          r_rd_pend;
    logic          r_rd_last;
    logic          w_accept;
    logic          w_issue;
    logic          w_issue_last;
    logic          w_pop;
    logic          w_credit;
    logic          w_empty;
    logic          w_head_last;
    logic [1:0]    w_cnt;
    logic [2:0]    w_fill;
    logic [W:0]    w_dout;

    assign w_accept     = (r_state == IDLE) && i_start;
    assign w_addr_inc   = (r_addr == ADDR_MAX) ? '0 : r_addr + 1'b1;
    assign w_issue_last = (r_issue_cnt == r_len - LEN_ONE);

    // Occupancy counting the in-flight read must stay below 2 after this cycle's pop.
    assign w_fill   = {1'b0, w_cnt} + {2'b00, r_rd_pend};
    assign w_credit = (w_fill < 3'd2) || (w_pop && (w_fill < 3'd3));
    assign w_issue  = (r_state == RUN) && (r_issue_cnt < r_len) && w_credit;

    // The BRAM samples the address every clock; hold the last issued one when idle.
    assign o_mem_addr = w_issue ? r_addr : r_mem_addr;

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = (i_len != '0) ? RUN : FIN;
                end
            end
            RUN: begin
                if (w_pop && w_head_last) begin
                    w_state_next = FIN;
                end
            end
            FIN: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_mem_addr  <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            if (w_accept && (i_len != '0)) begin
                r_addr      <= i_base;
                r_len       <= i_len;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_addr      <= w_addr_inc;
                r_issue_cnt <= r_issue_cnt + LEN_ONE;
            end
            if (w_issue) begin
                r_mem_addr <= r_addr;
                r_rd_last  <= w_issue_last;
            end
            r_rd_pend <= w_issue;
        end
    end

    stmm_skid_fifo #(
        .DW    (W + 1),
        .DEPTH (2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_rd_pend),
        .i_din   ({r_rd_last, i_mem_data}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_cnt   (w_cnt),
        .o_empty (w_empty)
    );

    assign o_out_valid = !w_empty;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_head_last = w_dout[W];
    assign o_out_data  = w_dout[W-1:0];
    assign o_out_last  = w_head_last && !w_empty;

endmodule

// File: tb/tb_bram_fetch.sv
// Directed bench for bram_fetch with a BRAM model and a row scoreboard.
module tb_bram_fetch;

    localparam int L  = 176;
    localparam int W  = 128;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          o_busy;
    logic          o_done;
    logic [AW-1:0] o_mem_addr;
    logic [W-1:0]  mem_q;
    logic          o_out_valid;
    logic          out_ready;
    logic [W-1:0]  o_out_data;
    logic          o_out_last;

    logic [W-1:0]  mem [L];
    logic [W:0]    sb [$];
    logic          prev_stall;
    logic [W:0]    prev_row;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= mem[o_mem_addr];

    bram_fetch #(.L(L), .W(W)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base      (base),
        .i_len       (len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_addr  (o_mem_addr),
        .i_mem_data  (mem_q),
        .o_out_valid (o_out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_start(input int b, input int n, input bit expect_rows);
        @(posedge clk); #1;
        start = 1'b1;
        base  = AW'(b);
        len   = (AW + 1)'(n);
        if (expect_rows) begin
            for (int k = 0; k < n; k++) begin
                sb.push_back({1'(k == n - 1), mem[(b + k) % L]});
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int t;
        t = 0;
        while (!o_done && t < 400) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            t++;
        end
        check("done_seen", 160'(o_done), 160'(1));
        check("sb_drained", 160'(sb.size()), 160'(0));
        out_ready = 1'b1;
    endtask

    // Output monitor: scoreboard pop on every handshake, hold check on every stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 160'(o_out_valid), 160'(1));
                check("stall_data", 160'({o_out_last, o_out_data}), 160'(prev_row));
            end
            if (o_busy) check("fifo_cnt_le2", 160'(u_dut.w_cnt <= 2'd2), 160'(1));
            if (o_out_valid && out_ready) begin
                check("row_expected", 160'(sb.size() > 0), 160'(1));
                if (sb.size() > 0) begin
                    check("row", 160'({o_out_last, o_out_data}), 160'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            prev_stall <= o_out_valid && !out_ready;
            prev_row   <= {o_out_last, o_out_data};
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base      = '0;
        len       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < L; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 160'(o_busy), 160'(0));
        check("rst_done", 160'(o_done), 160'(0));
        check("rst_valid", 160'(o_out_valid), 160'(0));
        check("rst_last", 160'(o_out_last), 160'(0));
        check("rst_addr", 160'(o_mem_addr), 160'(0));
        check("rst_data", 160'(o_out_data), 160'(0));
        @(negedge clk);
        rst = 1'b0;

        // 1: base 0, len 4, full throughput, exact cycle timing
        do_start(0, 4, 1'b1);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc <= 5) check("t1_addr", 160'(o_mem_addr), 160'((cyc - 1 < 3) ? cyc - 1 : 3));
            check("t1_valid", 160'(o_out_valid), 160'(cyc >= 3 && cyc <= 6));
            check("t1_last", 160'(o_out_last), 160'(cyc == 6));
            check("t1_done", 160'(o_done), 160'(cyc == 7));
            check("t1_busy", 160'(o_busy), 160'(cyc <= 7));
        end
        check("t1_sb_drained", 160'(sb.size()), 160'(0));

        // 2: wrap past the top of the BRAM
        do_start(174, 4, 1'b1);
        wait_done(1'b0);

        // 3: random backpressure
        do_start(10, 8, 1'b1);
        wait_done(1'b1);

        // 4: zero-length command
        do_start(30, 0, 1'b0);
        @(negedge clk);
        check("t4_busy_fin", 160'(o_busy), 160'(1));
        check("t4_done_fin", 160'(o_done), 160'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_busy_after", 160'(o_busy), 160'(0));
            check("t4_done_after", 160'(o_done), 160'(0));
            check("t4_valid", 160'(o_out_valid), 160'(0));
        end

        // 5: start while busy is ignored
        do_start(20, 6, 1'b1);
        @(posedge clk); #1;
        start = 1'b1;
        base  = AW'(100);
        len   = (AW + 1)'(3);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_idle_busy", 160'(o_busy), 160'(0));
            check("t5_idle_valid", 160'(o_out_valid), 160'(0));
        end

        // 6: async reset with one row buffered and one read in flight
        out_ready = 1'b0;
        do_start(40, 6, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_pre_cnt", 160'(u_dut.w_cnt), 160'(1));
        check("t6_pre_pend", 160'(u_dut.r_rd_pend), 160'(1));
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("t6_busy", 160'(o_busy), 160'(0));
        check("t6_done", 160'(o_done), 160'(0));
        check("t6_valid", 160'(o_out_valid), 160'(0));
        check("t6_last", 160'(o_out_last), 160'(0));
        check("t6_addr", 160'(o_mem_addr), 160'(0));
        check("t6_data", 160'(o_out_data), 160'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_no_done", 160'(o_done), 160'(0));
            check("t6_no_valid", 160'(o_out_valid), 160'(0));
        end
        out_ready = 1'b1;
        do_start(5, 2, 1'b1);
        wait_done(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
